// File: rtl/release_decrementer.sv
// -----------------------------------------------------------------------------
// release_decrementer
//   Release-phase level generator. A start request loads a level and a step.
//   The step is then subtracted every (rate+1) clocks until the level reaches
//   zero. The level saturates at zero, and borrow flags an underflow on the
//   final subtraction.
//
// Ports
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   start      in   1        request a new release (sampled only while busy=0)
//   level_in   in   WIDTH    starting level, latched on accepted start
//   step       in   WIDTH    per-step decrement, latched on accepted start
//   rate       in   RATE_W   clocks between steps minus one, latched on start
//   abort      in   1        cancel a running release (ignored while idle)
//   level_out  out  WIDTH    current level (registered)
//   busy       out  1        release in progress
//   done       out  1        one-cycle pulse after normal completion
//   borrow     out  1        final subtraction underflowed; held until next start
//   dbg_state  out  1        FSM state (0=IDLE, 1=RUN)
//
// Handshake: start is a level-sampled request. It is accepted on any rising
// edge where busy=0 and is otherwise ignored. There is no backpressure.
// -----------------------------------------------------------------------------
module release_decrementer #(
  parameter int WIDTH  = 12,
  parameter int RATE_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WIDTH-1:0]  level_in,
  input  logic [WIDTH-1:0]  step,
  input  logic [RATE_W-1:0] rate,
  input  logic              abort,
  output logic [WIDTH-1:0]  level_out,
  output logic              busy,
  output logic              done,
  output logic              borrow,
  output logic              dbg_state
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t            state;
  logic [WIDTH-1:0]  step_q;
  logic [RATE_W-1:0] rate_q;
  logic [RATE_W-1:0] cnt;

  // One extra bit so the MSB of the difference is the borrow out.
  logic [WIDTH:0]    sub;
  assign sub = {1'b0, level_out} - {1'b0, step_q};

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      level_out <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      borrow    <= 1'b0;
      step_q    <= '0;
      rate_q    <= '0;
      cnt       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            step_q    <= step;
            rate_q    <= rate;
            level_out <= level_in;
            borrow    <= 1'b0;
            if (level_in == '0 || step == '0) begin
              // Nothing to release: complete immediately without going busy.
              done <= 1'b1;
            end else begin
              cnt   <= rate;
              busy  <= 1'b1;
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (abort) begin
            // Level and borrow stay frozen; abort is not a normal completion.
            busy  <= 1'b0;
            state <= IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (sub[WIDTH]) begin
            level_out <= '0;
            borrow    <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end else if (sub[WIDTH-1:0] == '0) begin
            level_out <= '0;
            borrow    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end else begin
            level_out <= sub[WIDTH-1:0];
            cnt       <= rate_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_release_decrementer.sv
module tb_release_decrementer;

  localparam int WIDTH  = 12;
  localparam int RATE_W = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              start = 1'b0;
  logic [WIDTH-1:0]  level_in = '0;
  logic [WIDTH-1:0]  step = '0;
  logic [RATE_W-1:0] rate = '0;
  logic              abort = 1'b0;
  logic [WIDTH-1:0]  level_out;
  logic              busy;
  logic              done;
  logic              borrow;
  logic              dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  release_decrementer #(.WIDTH(WIDTH), .RATE_W(RATE_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .level_in  (level_in),
    .step      (step),
    .rate      (rate),
    .abort     (abort),
    .level_out (level_out),
    .busy      (busy),
    .done      (done),
    .borrow    (borrow),
    .dbg_state (dbg_state)
  );

  // driver tasks
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents a start request for exactly one edge (edge 0 of the run).
  task automatic launch(input logic [WIDTH-1:0] lvl, input logic [WIDTH-1:0] stp,
                        input logic [RATE_W-1:0] rt, input logic abt);
    level_in = lvl;
    step     = stp;
    rate     = rt;
    abort    = abt;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    abort    = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [WIDTH-1:0] lvl,
                            input logic b, input logic d, input logic br);
    check({tag, ".level"},  {20'd0, level_out}, {20'd0, lvl});
    check({tag, ".busy"},   {31'd0, busy},      {31'd0, b});
    check({tag, ".done"},   {31'd0, done},      {31'd0, d});
    check({tag, ".borrow"}, {31'd0, borrow},    {31'd0, br});
  endtask

  // Standard test-1 run from the accepted-start edge through the done pulse.
  task automatic run_t1(input string tag);
    launch(12'h100, 12'h040, 16'd2, 1'b0);
    check_outs({tag, ".e0"}, 12'h100, 1, 0, 0);
    tick(2);
    check_outs({tag, ".e2"}, 12'h100, 1, 0, 0);
    tick();
    check_outs({tag, ".e3"}, 12'h0C0, 1, 0, 0);
    tick(3);
    check_outs({tag, ".e6"}, 12'h080, 1, 0, 0);
    tick(3);
    check_outs({tag, ".e9"}, 12'h040, 1, 0, 0);
    tick(3);
    check_outs({tag, ".e12"}, 12'h000, 0, 1, 0);
    tick();
    check_outs({tag, ".e13"}, 12'h000, 0, 0, 0);
  endtask

  initial begin
    // reset
    tick(2);
    check_outs("reset", 12'h000, 0, 0, 0);
    check("reset.state", {31'd0, dbg_state}, 32'd0);
    #3 rst_n = 1'b1;
    tick();

    // test 1: nominal release
    run_t1("t1");

    // test 2: borrow on final step, rate=0
    launch(12'h005, 12'h003, 16'd0, 1'b0);
    check_outs("t2.e0", 12'h005, 1, 0, 0);
    tick();
    check_outs("t2.e1", 12'h002, 1, 0, 0);
    tick();
    check_outs("t2.e2", 12'h000, 0, 1, 1);
    tick();
    check_outs("t2.hold", 12'h000, 0, 0, 1);

    // test 3: exact zero, then zero-step start
    launch(12'hFFF, 12'hFFF, 16'd0, 1'b0);
    check_outs("t3.e0", 12'hFFF, 1, 0, 0);
    tick();
    check_outs("t3.e1", 12'h000, 0, 1, 0);
    tick();
    launch(12'h123, 12'h000, 16'd5, 1'b0);
    check_outs("t3.zstep", 12'h123, 0, 1, 0);
    tick();
    check_outs("t3.zstep+1", 12'h123, 0, 0, 0);
    launch(12'h000, 12'h010, 16'd0, 1'b0);
    check_outs("t3.zlevel", 12'h000, 0, 1, 0);
    tick();

    // test 4: start with abort high in IDLE is accepted, then abort mid-run
    launch(12'h800, 12'h100, 16'd3, 1'b1);
    check_outs("t4.e0", 12'h800, 1, 0, 0);
    tick(4);
    check_outs("t4.e4", 12'h700, 1, 0, 0);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_outs("t4.e6", 12'h700, 0, 0, 0);
    tick(4);
    check_outs("t4.after", 12'h700, 0, 0, 0);
    check("t4.state", {31'd0, dbg_state}, 32'd0);

    // test 5: start while busy is ignored; start on done cycle accepted
    launch(12'h100, 12'h040, 16'd2, 1'b0);
    tick();
    level_in = 12'hAAA;
    step     = 12'h001;
    rate     = 16'd0;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    check_outs("t5.e2", 12'h100, 1, 0, 0);
    tick();
    check_outs("t5.e3", 12'h0C0, 1, 0, 0);
    tick(3);
    check_outs("t5.e6", 12'h080, 1, 0, 0);
    tick(6);
    check_outs("t5.e12", 12'h000, 0, 1, 0);
    launch(12'h010, 12'h010, 16'd0, 1'b0);
    check_outs("t5.restart", 12'h010, 1, 0, 0);
    tick();
    check_outs("t5.restart.e1", 12'h000, 0, 1, 0);
    tick();

    // test 6: asynchronous reset mid-run
    launch(12'h100, 12'h040, 16'd2, 1'b0);
    tick(3);
    check_outs("t6.pre", 12'h0C0, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check_outs("t6.async", 12'h000, 0, 0, 0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    check_outs("t6.idle", 12'h000, 0, 0, 0);
    run_t1("t6.rerun");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
